// File: rtl/via_sr_streamer.sv
// -----------------------------------------------------------------------------
// via_sr_streamer
//
// Bus-master controller that configures a via6522 for shift-register output
// under Timer 2 (ACR mode 101, CB1 clock / CB2 data) and then streams bytes
// from a local FIFO into the VIA shift register. Byte completion is detected
// by polling IFR bit 2. With VIA_STREAM_IRQ_EN defined, the SR interrupt
// (via_irq) is used instead.
//
// Optional feature macro: VIA_STREAM_IRQ_EN
//   undefined (default) : IER gets 0x04 (SR interrupt disabled). POLL reads
//                         IFR every POLL_GAP idle clocks. via_irq is ignored.
//   defined             : IER gets 0x84 (SR interrupt enabled). POLL waits for
//                         via_irq and issues no IFR reads. POLL_GAP is unused.
//
// Parameters:
//   FIFO_DEPTH : byte FIFO entries (power of two, 2..64)
//   POLL_GAP   : idle clocks between successive IFR polls (>= 1)
//
// Ports:
//   clk, reset           : system clock, asynchronous active-high reset
//   start                : one-clk pulse, begins streaming when idle
//   stop                 : one-clk pulse, stop after the current byte
//   divisor[7:0]         : T2 low-latch value, sampled on an accepted start
//   wr_data/wr_valid     : host byte push
//   wr_ready             : FIFO not full (registered)
//   busy                 : high in every state except IDLE
//   underrun             : sticky, a byte finished while the FIFO was empty
//   byte_count[15:0]     : bytes loaded into SR since the last start
//   via_addr/via_wdata   : VIA register address / write data
//   via_rdata            : VIA read data
//   via_strobe/via_we    : VIA access strobe / write enable
//   via_irq              : VIA interrupt (only used with VIA_STREAM_IRQ_EN)
// -----------------------------------------------------------------------------
module via_sr_streamer #(
  parameter int FIFO_DEPTH = 8,
  parameter int POLL_GAP   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  divisor,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] byte_count,
  output logic [3:0]  via_addr,
  output logic [7:0]  via_wdata,
  input  logic [7:0]  via_rdata,
  output logic        via_strobe,
  output logic        via_we,
  input  logic        via_irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [3:0] ADDR_T2L = 4'h8;
  localparam logic [3:0] ADDR_SR  = 4'hA;
  localparam logic [3:0] ADDR_ACR = 4'hB;
  localparam logic [3:0] ADDR_IER = 4'hE;

  localparam logic [7:0] ACR_SR_OUT_T2 = 8'h14;
  localparam logic [7:0] ACR_OFF       = 8'h00;

`ifdef VIA_STREAM_IRQ_EN
  localparam logic [7:0] IER_VALUE = 8'h84;
`else
  localparam logic [3:0] ADDR_IFR  = 4'hD;
  localparam logic [7:0] IER_VALUE = 8'h04;
  localparam int PW = $clog2(POLL_GAP + 1);
  localparam logic [PW-1:0] GAP_LAST = PW'(POLL_GAP);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_ACR,
    S_CFG_T2,
    S_CFG_IER,
    S_WAIT,
    S_LOAD,
    S_POLL,
    S_SHUT
  } state_t;

  state_t state, next_state;

  // phase splits a write state into its strobe cycle and the mandatory idle
  // cycle, needed only where the following state strobes immediately
  logic phase, next_phase;

  logic [7:0]    divisor_q;
  logic          stop_pending;
  logic          fifo_pop;
  logic          fifo_push;
  logic          byte_done;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] fifo_count_next;
  logic [7:0]    fifo_head;

`ifndef VIA_STREAM_IRQ_EN
  logic [PW-1:0] poll_cnt;
`endif

  assign busy      = (state != S_IDLE);
  assign fifo_head = fifo_mem[rd_ptr];
  assign fifo_push = wr_valid && wr_ready;

`ifdef VIA_STREAM_IRQ_EN
  logic unused_inputs;
  assign unused_inputs = ^{via_rdata, 8'(POLL_GAP)};
`else
  logic unused_inputs;
  assign unused_inputs = ^{via_irq, via_rdata[7:3], via_rdata[1:0]};
`endif

  // State register for the sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      phase <= 1'b0;
    end else begin
      state <= next_state;
      phase <= next_phase;
    end
  end

  // Next-state and VIA bus decode. Every access is a single strobe cycle;
  // the idle cycle after it comes either from phase, from WAIT/IDLE (which
  // never strobe) or from the POLL wait count.
  always_comb begin
    next_state = state;
    next_phase = phase;
    via_strobe = 1'b0;
    via_we     = 1'b0;
    via_addr   = 4'h0;
    via_wdata  = 8'h00;
    fifo_pop   = 1'b0;
    byte_done  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_CFG_ACR;
          next_phase = 1'b0;
        end
      end

      S_CFG_ACR: begin
        if (!phase) begin
          via_strobe = 1'b1;
          via_we     = 1'b1;
          via_addr   = ADDR_ACR;
          via_wdata  = ACR_SR_OUT_T2;
          next_phase = 1'b1;
        end else begin
          next_phase = 1'b0;
          next_state = S_CFG_T2;
        end
      end

      S_CFG_T2: begin
        if (!phase) begin
          via_strobe = 1'b1;
          via_we     = 1'b1;
          via_addr   = ADDR_T2L;
          via_wdata  = divisor_q;
          next_phase = 1'b1;
        end else begin
          next_phase = 1'b0;
          next_state = S_CFG_IER;
        end
      end

      S_CFG_IER: begin
        via_strobe = 1'b1;
        via_we     = 1'b1;
        via_addr   = ADDR_IER;
        via_wdata  = IER_VALUE;
        next_state = S_WAIT;
      end

      // A pending stop is honoured only here, between bytes
      S_WAIT: begin
        if (stop_pending) begin
          next_state = S_SHUT;
        end else if (fifo_count != '0) begin
          next_state = S_LOAD;
        end
      end

      // Writing SR restarts the shifter and clears IFR bit 2 in the VIA
      S_LOAD: begin
        via_strobe = 1'b1;
        via_we     = 1'b1;
        via_addr   = ADDR_SR;
        via_wdata  = fifo_head;
        fifo_pop   = 1'b1;
        next_state = S_POLL;
      end

      S_POLL: begin
`ifdef VIA_STREAM_IRQ_EN
        if (via_irq) begin
          byte_done  = 1'b1;
          next_state = S_WAIT;
        end
`else
        // The read strobe cycle is also the sample cycle: via_rdata is
        // taken at the edge that closes the strobe.
        if (poll_cnt == GAP_LAST) begin
          via_strobe = 1'b1;
          via_addr   = ADDR_IFR;
          if (via_rdata[2]) begin
            byte_done  = 1'b1;
            next_state = S_WAIT;
          end
        end
`endif
      end

      S_SHUT: begin
        via_strobe = 1'b1;
        via_we     = 1'b1;
        via_addr   = ADDR_ACR;
        via_wdata  = ACR_OFF;
        next_state = S_IDLE;
      end

      default: begin
        next_state = S_IDLE;
        next_phase = 1'b0;
      end
    endcase
  end

`ifndef VIA_STREAM_IRQ_EN
  // Idle clocks before each IFR read; restarts after every read so that
  // consecutive polls are POLL_GAP idle clocks apart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt <= '0;
    end else if (state != S_POLL || poll_cnt == GAP_LAST) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end
`endif

  // Run bookkeeping: divisor latch, stop request, underrun and byte count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor_q    <= 8'h00;
      stop_pending <= 1'b0;
      underrun     <= 1'b0;
      byte_count   <= 16'h0000;
    end else begin
      if (state == S_IDLE) begin
        stop_pending <= 1'b0;
      end else if (stop) begin
        stop_pending <= 1'b1;
      end

      if (state == S_IDLE && start) begin
        divisor_q  <= divisor;
        underrun   <= 1'b0;
        byte_count <= 16'h0000;
      end else begin
        if (fifo_pop) begin
          byte_count <= byte_count + 16'h0001;
        end
        if (byte_done && fifo_count == '0) begin
          underrun <= 1'b1;
        end
      end
    end
  end

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    fifo_count_next = fifo_count;
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_count_next = fifo_count + 1'b1;
      2'b01:   fifo_count_next = fifo_count - 1'b1;
      default: fifo_count_next = fifo_count;
    endcase
  end

  // FIFO pointers, count and registered ready flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      wr_ready   <= 1'b1;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_count <= fifo_count_next;
      wr_ready   <= (fifo_count_next < DEPTH_C);
    end
  end

  // FIFO storage needs no reset; emptiness is tracked by the pointers
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_via_sr_streamer.sv
// -----------------------------------------------------------------------------
// tb_via_sr_streamer
//
// Self-checking bench for via_sr_streamer. A small behavioural VIA answers the
// register bus (ACR, T2L, IER, SR, IFR bit 2) and records the bytes it shifts
// out. Expected bus traffic, shifted bytes, counts and flags are built from a
// byte queue and the controller's documented write sequence.
// Works for both the default build and VIA_STREAM_IRQ_EN.
// -----------------------------------------------------------------------------
module tb_via_sr_streamer;

  localparam int FIFO_DEPTH = 8;
  localparam int POLL_GAP   = 4;

`ifdef VIA_STREAM_IRQ_EN
  localparam logic [7:0] IER_EXP = 8'h84;
`else
  localparam logic [7:0] IER_EXP = 8'h04;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [7:0]  divisor;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        busy;
  logic        underrun;
  logic [15:0] byte_count;
  logic [3:0]  via_addr;
  logic [7:0]  via_wdata;
  logic [7:0]  via_rdata;
  logic        via_strobe;
  logic        via_we;
  logic        via_irq;

  int errors = 0;
  int checks = 0;

  // behavioural VIA state
  logic [7:0] via_acr   = 8'h00;
  logic [7:0] via_t2l   = 8'h00;
  logic [6:0] via_ier   = 7'h00;
  logic       ifr2      = 1'b0;
  bit         shifting  = 1'b0;
  int         shift_timer = 0;

  // monitor statistics
  int cyc = 0;
  int accesses = 0;
  int sr_writes = 0;
  int reads = 0;
  int b2b = 0;
  int bad_rd_addr = 0;
  int bad_gap = 0;
  int bad_lat = 0;
  int last_acc_cyc = 0;
  int start_cyc = 0;
  int first_lat = -1;
  bit want_first = 1'b0;
  bit prev_strobe = 1'b0;
  bit irq_prev = 1'b0;
  bit done_wait = 1'b0;
  int done_cyc = 0;
  int bytes_held = 0;

  // reference model
  logic [7:0]  model_fifo [$];
  logic [11:0] exp_log [$];
  logic [11:0] act_log [$];
  logic [7:0]  exp_cap [$];
  logic [7:0]  cap [$];
  bit          model_running = 1'b0;

  assign via_rdata = (via_addr == 4'hD) ? {5'b00000, ifr2, 2'b00} : 8'h00;
  assign via_irq   = ifr2 && via_ier[2];

  via_sr_streamer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .POLL_GAP   (POLL_GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .divisor    (divisor),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .underrun   (underrun),
    .byte_count (byte_count),
    .via_addr   (via_addr),
    .via_wdata  (via_wdata),
    .via_rdata  (via_rdata),
    .via_strobe (via_strobe),
    .via_we     (via_we),
    .via_irq    (via_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any failure
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // VIA model and bus monitor, evaluated mid-cycle on the falling edge.
  // done_wait arms when a byte is known finished (IFR read of 1 or an IRQ
  // rise) with bytes still queued, and measures the delay to the next SR write.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (shifting) begin
        if (shift_timer <= 1) begin
          shifting = 1'b0;
          ifr2     = 1'b1;
        end else begin
          shift_timer--;
        end
      end
      if (ifr2 && via_ier[2] && !irq_prev && bytes_held > 0) begin
        done_wait = 1'b1;
        done_cyc  = cyc;
      end
      if (via_strobe) begin
        accesses++;
        if (prev_strobe) b2b++;
        if (want_first) begin
          first_lat  = cyc - start_cyc;
          want_first = 1'b0;
        end
        if (via_we) begin
          act_log.push_back({via_addr, via_wdata});
          case (via_addr)
            4'hB: begin
              via_acr   = via_wdata;
              done_wait = 1'b0;
            end
            4'h8: via_t2l = via_wdata;
            4'hE: begin
              if (via_wdata[7]) via_ier = via_ier | via_wdata[6:0];
              else              via_ier = via_ier & ~via_wdata[6:0];
            end
            4'hA: begin
              sr_writes++;
              if (bytes_held > 0) bytes_held--;
              ifr2        = 1'b0;
              shifting    = 1'b1;
              shift_timer = 4 * (int'(via_t2l) + 2);
              if (via_acr[4:2] == 3'b101) cap.push_back(via_wdata);
              if (done_wait) begin
                if (cyc - done_cyc > 3) bad_lat++;
                done_wait = 1'b0;
              end
            end
            default: ;
          endcase
        end else begin
          reads++;
          if (via_addr != 4'hD) bad_rd_addr++;
          if (cyc - last_acc_cyc != POLL_GAP + 1) bad_gap++;
          if (ifr2 && bytes_held > 0) begin
            done_wait = 1'b1;
            done_cyc  = cyc;
          end
        end
        last_acc_cyc = cyc;
      end
      if (start && !busy) begin
        start_cyc  = cyc;
        want_first = 1'b1;
      end
      prev_strobe = via_strobe;
      irq_prev    = ifr2 && via_ier[2];
    end
  end

  // Push one byte; the model keeps it only if the FIFO has room
  task automatic apply_push(input logic [7:0] b);
    @(posedge clk); #1;
    wr_data  = b;
    wr_valid = 1'b1;
    if (model_fifo.size() < FIFO_DEPTH) begin
      model_fifo.push_back(b);
      bytes_held++;
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  // One-clock start pulse; from idle this adds the configuration writes
  task automatic apply_start(input logic [7:0] d);
    @(posedge clk); #1;
    start   = 1'b1;
    divisor = d;
    if (!model_running) begin
      exp_log.push_back({4'hB, 8'h14});
      exp_log.push_back({4'h8, d});
      exp_log.push_back({4'hE, IER_EXP});
      model_running = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic apply_stop();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  // The next n queued bytes are expected to go out through SR
  task automatic send_expected(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = model_fifo.pop_front();
      exp_log.push_back({4'hA, b});
      exp_cap.push_back(b);
    end
  endtask

  task automatic expect_shutdown();
    exp_log.push_back({4'hB, 8'h00});
    model_running = 1'b0;
  endtask

  task automatic wait_sr(input int target, input string tag);
    int n = 0;
    while (sr_writes < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 32'(sr_writes >= target), 32'd1);
  endtask

  task automatic wait_underrun(input string tag);
    int n = 0;
    while (underrun !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 32'(underrun), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 32'(busy), 32'd0);
  endtask

  task automatic compare_logs(input string tag);
    check_output({tag, "_log_len"}, act_log.size(), exp_log.size());
    for (int i = 0; i < act_log.size() && i < exp_log.size(); i++)
      check_output($sformatf("%s_log%0d", tag, i), 32'(act_log[i]), 32'(exp_log[i]));
    check_output({tag, "_cap_len"}, cap.size(), exp_cap.size());
    for (int i = 0; i < cap.size() && i < exp_cap.size(); i++)
      check_output($sformatf("%s_cap%0d", tag, i), 32'(cap[i]), 32'(exp_cap[i]));
    act_log.delete();
    exp_log.delete();
    cap.delete();
    exp_cap.delete();
  endtask

  initial begin
    int base;
    int acc0;
    logic [7:0] d;

    reset    = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    divisor  = 8'h00;
    wr_data  = 8'h00;
    wr_valid = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy",   32'(busy),       32'd0);
    check_output("rst_strobe", 32'(via_strobe), 32'd0);
    check_output("rst_we",     32'(via_we),     32'd0);
    check_output("rst_addr",   32'(via_addr),   32'd0);
    check_output("rst_wdata",  32'(via_wdata),  32'd0);
    check_output("rst_under",  32'(underrun),   32'd0);
    check_output("rst_count",  32'(byte_count), 32'd0);
    check_output("rst_ready",  32'(wr_ready),   32'd1);
    reset = 1'b0;

    // preloaded bytes stream in order; start while busy is ignored
    $display("[TB] preload and stream three bytes");
    apply_push(8'hA5);
    apply_push(8'h3C);
    apply_push(8'h0F);
    base = sr_writes;
    apply_start(8'h10);
    wait_sr(base + 1, "t1_first_sr");
    check_output("t1_start_lat", first_lat, 32'd1);
    apply_start(8'h77);
    wait_underrun("t1_underrun");
    send_expected(3);
    check_output("t1_count", 32'(byte_count), 32'd3);
    check_output("t1_busy",  32'(busy),       32'd1);
    check_output("t1_t2l",   32'(via_t2l),    32'h10);
    apply_stop();
    wait_idle("t1_idle");
    expect_shutdown();
    check_output("t1_under_sticky", 32'(underrun), 32'd1);
    compare_logs("t1");

    // overfilling the FIFO while idle
    $display("[TB] overfill FIFO");
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      apply_push(8'($urandom));
      @(negedge clk);
      check_output($sformatf("t2_ready%0d", i), 32'(wr_ready),
                   32'(model_fifo.size() < FIFO_DEPTH));
    end
    base = sr_writes;
    apply_start(8'($urandom_range(1, 12)));
    wait_underrun("t2_underrun");
    send_expected(FIFO_DEPTH);
    check_output("t2_count",  32'(byte_count),     32'(FIFO_DEPTH));
    check_output("t2_srs",    sr_writes - base,    32'(FIFO_DEPTH));
    check_output("t2_ready",  32'(wr_ready),       32'd1);
    apply_stop();
    wait_idle("t2_idle");
    expect_shutdown();
    compare_logs("t2");

    // stop while the second of four bytes is shifting, then resume
    $display("[TB] stop mid-stream and restart");
    for (int i = 0; i < 4; i++) apply_push(8'($urandom));
    base = sr_writes;
    apply_start(8'($urandom_range(1, 12)));
    wait_sr(base + 2, "t3_second_sr");
    apply_stop();
    wait_idle("t3_idle");
    send_expected(2);
    expect_shutdown();
    check_output("t3_count", 32'(byte_count), 32'd2);
    check_output("t3_under", 32'(underrun),   32'd0);
    compare_logs("t3");
    d = 8'($urandom_range(1, 12));
    apply_start(d);
    wait_underrun("t3b_underrun");
    send_expected(2);
    check_output("t3b_count", 32'(byte_count), 32'd2);
    check_output("t3b_t2l",   32'(via_t2l),    32'(d));
    apply_stop();
    wait_idle("t3b_idle");
    expect_shutdown();
    compare_logs("t3b");

    // asynchronous reset while polling
    $display("[TB] reset during POLL");
    for (int i = 0; i < 3; i++) apply_push(8'($urandom));
    base = sr_writes;
    apply_start(8'($urandom_range(4, 12)));
    wait_sr(base + 1, "t4_first_sr");
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_output("t4_async_busy",   32'(busy),       32'd0);
    check_output("t4_async_strobe", 32'(via_strobe), 32'd0);
    send_expected(1);
    model_fifo.delete();
    model_running = 1'b0;
    bytes_held    = 0;
    done_wait     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("t4_ready", 32'(wr_ready), 32'd1);
    reset = 1'b0;
    acc0 = accesses;
    repeat (40) @(negedge clk);
    check_output("t4_quiet", accesses - acc0, 32'd0);
    compare_logs("t4");
    base = sr_writes;
    apply_start(8'($urandom_range(1, 12)));
    repeat (60) @(negedge clk);
    check_output("t4_empty_srs", sr_writes - base, 32'd0);
    check_output("t4_empty_busy", 32'(busy), 32'd1);
    check_output("t4_start_lat", first_lat, 32'd1);
    apply_stop();
    wait_idle("t4_idle");
    expect_shutdown();
    compare_logs("t4b");

    // bus protocol over the whole run
    check_output("back_to_back", b2b,         32'd0);
    check_output("read_addr",    bad_rd_addr, 32'd0);
    check_output("poll_gap",     bad_gap,     32'd0);
    check_output("done_to_sr",   bad_lat,     32'd0);
`ifdef VIA_STREAM_IRQ_EN
    check_output("ifr_reads", reads, 32'd0);
`else
    check_output("ifr_reads_seen", 32'(reads > 0), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
